// File: rtl/vending_pkg.sv
// Shared definitions for the multi-item vending controller: coin encodings,
// denomination values in nickels and the controller state enum.
package vending_pkg;

    localparam int N_DENOM = 5;

    localparam logic [N_DENOM-1:0] COIN_NICKEL  = 5'b00001;
    localparam logic [N_DENOM-1:0] COIN_DIME    = 5'b00010;
    localparam logic [N_DENOM-1:0] COIN_QUARTER = 5'b00100;
    localparam logic [N_DENOM-1:0] COIN_HALF    = 5'b01000;
    localparam logic [N_DENOM-1:0] COIN_DOLLAR  = 5'b10000;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_VEND    = 2'd2,
        S_CHANGE  = 2'd3
    } state_e;

    function automatic logic [4:0] denom_value(input int idx);
        case (idx)
            0:       return 5'd1;
            1:       return 5'd2;
            2:       return 5'd5;
            3:       return 5'd10;
            default: return 5'd20;
        endcase
    endfunction

    // Only meaningful for a one-hot coin; callers check one-hotness separately.
    function automatic logic [4:0] coin_value(input logic [N_DENOM-1:0] c);
        logic [4:0] v;
        v = '0;
        for (int i = 0; i < N_DENOM; i++) begin
            if (c[i]) v = v | denom_value(i);
        end
        return v;
    endfunction

endpackage

// File: rtl/change_picker.sv
// Greedy change selector: largest stocked denomination not exceeding the
// remaining credit. Purely combinational.
module change_picker
    import vending_pkg::*;
#(
    parameter int CREDIT_W = 6
) (
    input  logic [CREDIT_W-1:0] credit_i,
    input  logic [N_DENOM-1:0]  bank_i,
    output logic [N_DENOM-1:0]  coin_o,
    output logic [CREDIT_W-1:0] value_o,
    output logic                none_o
);

    localparam int VAL_W = (CREDIT_W > 5) ? CREDIT_W : 5;

    // Ascending scan: the last hit wins, so the largest eligible coin is kept.
    always_comb begin
        coin_o  = '0;
        value_o = '0;
        none_o  = 1'b1;
        for (int i = 0; i < N_DENOM; i++) begin
            if (bank_i[i] && (VAL_W'(denom_value(i)) <= VAL_W'(credit_i))) begin
                coin_o    = '0;
                coin_o[i] = 1'b1;
                value_o   = CREDIT_W'(denom_value(i));
                none_o    = 1'b0;
            end
        end
    end

endmodule

// File: rtl/vending_machine_n.sv
// Multi-item vending controller: credit accumulation, single-price vend,
// greedy one-coin-per-cycle change/refund with short-change reporting.
module vending_machine_n
    import vending_pkg::*;
#(
    parameter int N_ITEMS  = 6,
    parameter int PRICE    = 30,
    parameter int CREDIT_W = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                coin_valid,
    input  logic [4:0]          coin,
    input  logic                select_valid,
    input  logic [N_ITEMS-1:0]  item_select,
    input  logic [N_ITEMS-1:0]  inventory,
    input  logic                cancel,
    input  logic [4:0]          bank,
    output logic [N_ITEMS-1:0]  dispense_item,
    output logic [4:0]          dispense_change,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy,
    output logic                coin_reject,
    output logic                select_nak,
    output logic                change_short
);

    localparam int SUM_W = ((CREDIT_W > 5) ? CREDIT_W : 5) + 1;
    localparam logic [SUM_W-1:0] CREDIT_MAX = SUM_W'((1 << CREDIT_W) - 1);
    localparam logic [SUM_W-1:0] PRICE_W    = SUM_W'(PRICE);

    state_e               state_q, state_d;
    logic [CREDIT_W-1:0]  credit_q, credit_d;
    logic [N_ITEMS-1:0]   item_q, item_d;
    logic [N_DENOM-1:0]   chg_q, chg_d;
    logic                 busy_q, busy_d;
    logic                 rej_q, rej_d;
    logic                 nak_q, nak_d;
    logic                 short_q, short_d;

    logic [N_DENOM-1:0]   pick_coin;
    logic [CREDIT_W-1:0]  pick_val;
    logic                 pick_none;
    logic [SUM_W-1:0]     coin_sum;
    logic                 coin_ok, sel_ok, do_pay;

    change_picker #(.CREDIT_W(CREDIT_W)) u_picker (
        .credit_i (credit_q),
        .bank_i   (bank),
        .coin_o   (pick_coin),
        .value_o  (pick_val),
        .none_o   (pick_none)
    );

    assign coin_sum = SUM_W'(credit_q) + SUM_W'(coin_value(coin));
    assign coin_ok  = $onehot(coin) && (coin_sum <= CREDIT_MAX);
    assign sel_ok   = $onehot(item_select) && (|(item_select & inventory))
                      && (SUM_W'(credit_q) >= PRICE_W);

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        item_d   = '0;
        chg_d    = '0;
        rej_d    = 1'b0;
        nak_d    = 1'b0;
        short_d  = 1'b0;
        do_pay   = 1'b0;

        case (state_q)
            S_IDLE, S_COLLECT: begin
                // cancel > coin > select; cancel means nothing with zero credit
                if (cancel && (state_q == S_COLLECT)) begin
                    do_pay = 1'b1;
                    rej_d  = coin_valid;
                    nak_d  = select_valid;
                end else if (coin_valid) begin
                    nak_d = select_valid;
                    if (coin_ok) begin
                        credit_d = coin_sum[CREDIT_W-1:0];
                        state_d  = S_COLLECT;
                    end else begin
                        rej_d = 1'b1;
                    end
                end else if (select_valid) begin
                    if (sel_ok) begin
                        item_d   = item_select;
                        credit_d = credit_q - CREDIT_W'(PRICE);
                        state_d  = S_VEND;
                    end else begin
                        nak_d = 1'b1;
                    end
                end
            end
            default: begin
                rej_d = coin_valid;
                nak_d = select_valid;
                if (credit_q == '0) state_d = S_IDLE;
                else                do_pay  = 1'b1;
            end
        endcase

        // One payout step: the first refund/change coin is issued on the same
        // edge that enters CHANGE, so it shows one cycle after cancel/vend.
        if (do_pay) begin
            if (pick_none) begin
                short_d = 1'b1;
                state_d = S_COLLECT;
            end else begin
                chg_d    = pick_coin;
                credit_d = credit_q - pick_val;
                state_d  = (credit_q == pick_val) ? S_IDLE : S_CHANGE;
            end
        end

        busy_d = (state_d == S_VEND) || (state_d == S_CHANGE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            credit_q <= '0;
            item_q   <= '0;
            chg_q    <= '0;
            busy_q   <= 1'b0;
            rej_q    <= 1'b0;
            nak_q    <= 1'b0;
            short_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            item_q   <= item_d;
            chg_q    <= chg_d;
            busy_q   <= busy_d;
            rej_q    <= rej_d;
            nak_q    <= nak_d;
            short_q  <= short_d;
        end
    end

    assign dispense_item   = item_q;
    assign dispense_change = chg_q;
    assign credit          = credit_q;
    assign busy            = busy_q;
    assign coin_reject     = rej_q;
    assign select_nak      = nak_q;
    assign change_short    = short_q;

endmodule

// File: tb/tb_vending_machine_n.sv
// Scoreboard bench: stimulus queues hand-computed output events, a negedge
// monitor pops and compares whenever the DUT pulses or credit changes.
module tb_vending_machine_n;

    localparam int N_ITEMS  = 6;
    localparam int PRICE    = 30;
    localparam int CREDIT_W = 6;

    logic                clk = 1'b0;
    logic                rst_n = 1'b1;
    logic                coin_valid = 1'b0;
    logic [4:0]          coin = '0;
    logic                select_valid = 1'b0;
    logic [N_ITEMS-1:0]  item_select = '0;
    logic [N_ITEMS-1:0]  inventory = '1;
    logic                cancel = 1'b0;
    logic [4:0]          bank = 5'b11111;
    logic [N_ITEMS-1:0]  dispense_item;
    logic [4:0]          dispense_change;
    logic [CREDIT_W-1:0] credit;
    logic                busy, coin_reject, select_nak, change_short;

    typedef struct packed {
        logic [5:0] item;
        logic [4:0] chg;
        logic [5:0] credit;
        logic       busy;
        logic       rej;
        logic       nak;
        logic       shrt;
    } obs_t;

    obs_t  exp_q[$];
    string name_q[$];
    int    vectors = 0;
    int    miscompares = 0;

    vending_machine_n #(.N_ITEMS(N_ITEMS), .PRICE(PRICE), .CREDIT_W(CREDIT_W)) dut (
        .clk             (clk),
        .reset           (rst_n),
        .coin_valid      (coin_valid),
        .coin            (coin),
        .select_valid    (select_valid),
        .item_select     (item_select),
        .inventory       (inventory),
        .cancel          (cancel),
        .bank            (bank),
        .dispense_item   (dispense_item),
        .dispense_change (dispense_change),
        .credit          (credit),
        .busy            (busy),
        .coin_reject     (coin_reject),
        .select_nak      (select_nak),
        .change_short    (change_short)
    );

    always #5 clk = ~clk;

    task automatic expect_ev(input string nm, input logic [5:0] item, input logic [4:0] chg,
                             input int cr, input int b, input int r, input int n, input int s);
        obs_t e;
        e = {item, chg, 6'(cr), 1'(b), 1'(r), 1'(n), 1'(s)};
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        coin_valid   = 1'b0;
        select_valid = 1'b0;
        cancel       = 1'b0;
    endtask

    task automatic put_coin(input logic [4:0] c);
        coin_valid = 1'b1;
        coin       = c;
        tick();
    endtask

    task automatic sel(input logic [5:0] it);
        select_valid = 1'b1;
        item_select  = it;
        tick();
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic check_zero(input string nm);
        obs_t got;
        got = {dispense_item, dispense_change, credit, busy, coin_reject, select_nak, change_short};
        vectors++;
        if (got !== '0) begin
            miscompares++;
            $display("FAIL %s: outputs=%h, want all zero", nm, got);
        end
    endtask

    // Monitor
    initial begin
        logic [5:0] prev;
        obs_t       got, want;
        string      nm;
        prev = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev = '0;
            end else begin
                got = {dispense_item, dispense_change, credit, busy, coin_reject, select_nak, change_short};
                if ((|got.item) || (|got.chg) || got.rej || got.nak || got.shrt || (got.credit != prev)) begin
                    vectors++;
                    if (exp_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL unexpected_event: got item=%b chg=%b credit=%0d busy=%b rej=%b nak=%b short=%b, want no event",
                                 got.item, got.chg, got.credit, got.busy, got.rej, got.nak, got.shrt);
                    end else begin
                        want = exp_q.pop_front();
                        nm   = name_q.pop_front();
                        if (got !== want) begin
                            miscompares++;
                            $display("FAIL %s: got item=%b chg=%b credit=%0d busy=%b rej=%b nak=%b short=%b, want item=%b chg=%b credit=%0d busy=%b rej=%b nak=%b short=%b",
                                     nm, got.item, got.chg, got.credit, got.busy, got.rej, got.nak, got.shrt,
                                     want.item, want.chg, want.credit, want.busy, want.rej, want.nak, want.shrt);
                        end
                    end
                end
                prev = got.credit;
            end
        end
    end

    // Stimulus
    initial begin
        #1 rst_n = 1'b0;
        #1 check_zero("reset_state");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);

        // IDLE boundaries: non-one-hot coin, select with no credit
        expect_ev("two_hot_coin", 6'b0, 5'b0, 0, 0, 1, 0, 0);
        put_coin(5'b00011);
        expect_ev("sel_no_credit", 6'b0, 5'b0, 0, 0, 0, 1, 0);
        sel(6'b000100);

        // Six quarters, empty slot refused, then exact-price vend
        for (int k = 1; k <= 6; k++) begin
            expect_ev("quarter", 6'b0, 5'b0, 5 * k, 0, 0, 0, 0);
            put_coin(5'b00100);
        end
        inventory = 6'b111011;
        expect_ev("sel_empty_slot", 6'b0, 5'b0, 30, 0, 0, 1, 0);
        sel(6'b000100);
        inventory = '1;
        expect_ev("vend_exact", 6'b000100, 5'b0, 0, 1, 0, 0, 0);
        sel(6'b000100);
        idle(4);

        // 40 -> vend, one half-dollar back
        expect_ev("dollar1", 6'b0, 5'b0, 20, 0, 0, 0, 0);
        put_coin(5'b10000);
        expect_ev("dollar2", 6'b0, 5'b0, 40, 0, 0, 0, 0);
        put_coin(5'b10000);
        expect_ev("vend40", 6'b000001, 5'b0, 10, 1, 0, 0, 0);
        expect_ev("chg40_half", 6'b0, 5'b01000, 0, 0, 0, 0, 0);
        sel(6'b000001);
        idle(4);

        // 37 with only dimes/nickels stocked: 2,2,2,1
        bank = 5'b00011;
        expect_ev("c37_a", 6'b0, 5'b0, 20, 0, 0, 0, 0);
        put_coin(5'b10000);
        expect_ev("c37_b", 6'b0, 5'b0, 30, 0, 0, 0, 0);
        put_coin(5'b01000);
        expect_ev("c37_c", 6'b0, 5'b0, 35, 0, 0, 0, 0);
        put_coin(5'b00100);
        expect_ev("c37_d", 6'b0, 5'b0, 37, 0, 0, 0, 0);
        put_coin(5'b00010);
        expect_ev("vend37", 6'b100000, 5'b0, 7, 1, 0, 0, 0);
        expect_ev("chg37_dime1", 6'b0, 5'b00010, 5, 1, 0, 0, 0);
        expect_ev("chg37_dime2", 6'b0, 5'b00010, 3, 1, 0, 0, 0);
        expect_ev("chg37_dime3", 6'b0, 5'b00010, 1, 1, 0, 0, 0);
        expect_ev("chg37_nickel", 6'b0, 5'b00001, 0, 0, 0, 0, 0);
        sel(6'b100000);
        idle(6);

        // 33 with dimes only: one dime then short with 1 left, back to COLLECT
        bank = 5'b00010;
        expect_ev("c33_a", 6'b0, 5'b0, 20, 0, 0, 0, 0);
        put_coin(5'b10000);
        expect_ev("c33_b", 6'b0, 5'b0, 30, 0, 0, 0, 0);
        put_coin(5'b01000);
        expect_ev("c33_c", 6'b0, 5'b0, 32, 0, 0, 0, 0);
        put_coin(5'b00010);
        expect_ev("c33_d", 6'b0, 5'b0, 33, 0, 0, 0, 0);
        put_coin(5'b00001);
        expect_ev("vend33", 6'b000010, 5'b0, 3, 1, 0, 0, 0);
        expect_ev("chg33_dime", 6'b0, 5'b00010, 1, 1, 0, 0, 0);
        expect_ev("chg33_short", 6'b0, 5'b0, 1, 0, 0, 0, 1);
        sel(6'b000010);
        idle(3);
        expect_ev("cancel_short", 6'b0, 5'b0, 1, 0, 0, 0, 1);
        cancel = 1'b1;
        tick();
        idle(2);
        bank = 5'b11111;
        expect_ev("cancel_nickel", 6'b0, 5'b00001, 0, 0, 0, 0, 0);
        cancel = 1'b1;
        tick();
        idle(3);

        // Credit ceiling, coin beats select, coin while busy
        expect_ev("c62_a", 6'b0, 5'b0, 20, 0, 0, 0, 0);
        put_coin(5'b10000);
        expect_ev("c62_b", 6'b0, 5'b0, 40, 0, 0, 0, 0);
        put_coin(5'b10000);
        expect_ev("c62_c", 6'b0, 5'b0, 60, 0, 0, 0, 0);
        put_coin(5'b10000);
        expect_ev("c62_d", 6'b0, 5'b0, 62, 0, 0, 0, 0);
        put_coin(5'b00010);
        expect_ev("overflow_dollar", 6'b0, 5'b0, 62, 0, 1, 0, 0);
        put_coin(5'b10000);
        expect_ev("coin_beats_sel", 6'b0, 5'b0, 63, 0, 0, 1, 0);
        select_valid = 1'b1;
        item_select  = 6'b001000;
        put_coin(5'b00001);
        expect_ev("overflow_nickel", 6'b0, 5'b0, 63, 0, 1, 0, 0);
        put_coin(5'b00001);
        expect_ev("vend63", 6'b001000, 5'b0, 33, 1, 0, 0, 0);
        expect_ev("chg63_dollar_busy_coin", 6'b0, 5'b10000, 13, 1, 1, 0, 0);
        expect_ev("chg63_half", 6'b0, 5'b01000, 3, 1, 0, 0, 0);
        expect_ev("chg63_dime", 6'b0, 5'b00010, 1, 1, 0, 0, 0);
        expect_ev("chg63_nickel", 6'b0, 5'b00001, 0, 0, 0, 0, 0);
        sel(6'b001000);
        put_coin(5'b00010);
        idle(6);

        // Cancel ignored in IDLE, refund 15 as half+nickel..., reset mid-payout
        bank = 5'b01001;
        expect_ev("idle_cancel_coin", 6'b0, 5'b0, 10, 0, 0, 0, 0);
        cancel = 1'b1;
        put_coin(5'b01000);
        expect_ev("c15", 6'b0, 5'b0, 15, 0, 0, 0, 0);
        put_coin(5'b00100);
        expect_ev("refund_half", 6'b0, 5'b01000, 5, 1, 0, 0, 0);
        expect_ev("refund_nickel", 6'b0, 5'b00001, 4, 1, 0, 0, 0);
        cancel = 1'b1;
        tick();
        tick();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_zero("reset_mid_payout");
        idle(3);
        rst_n = 1'b1;
        bank  = 5'b11111;
        idle(6);

        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected events never seen, want 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
